// File: rtl/noc_port_arb.sv
// noc_port_arb: wormhole output-port arbiter, round-robin at packet granularity.
// Define NOC_PORT_ARB_PKT_CNT_EN to add the pkt_cnt/pkt_cnt_clr completed-packet counter.
module noc_port_arb #(
  parameter int unsigned N      = 5,
  parameter int unsigned DATA_W = 64,
  localparam int unsigned GNT_W = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        s_tvalid,
  output logic [N-1:0]        s_tready,
  input  logic [N*DATA_W-1:0] s_tdata,
  input  logic [N-1:0]        s_tlast,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic [DATA_W-1:0]   m_tdata,
  output logic                m_tlast,
  output logic [N-1:0]        gnt_oh,
  output logic                busy
`ifdef NOC_PORT_ARB_PKT_CNT_EN
  ,
  input  logic                pkt_cnt_clr,
  output logic [15:0]         pkt_cnt
`endif
);

  localparam int unsigned SUM_W = GNT_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [GNT_W-1:0] gnt, gnt_next;
  logic [GNT_W-1:0] ptr, ptr_next;
  logic [GNT_W-1:0] pick;
  logic [SUM_W-1:0] rr_sum;
  logic [N-1:0]     gnt_oh_next;
  logic             busy_next;
  logic             last_hs;

  // Round-robin pick: first requester above ptr, wrapping modulo N.
  // Scanning offsets from largest to smallest lets the nearest one win.
  always_comb begin
    pick   = ptr;
    rr_sum = '0;
    for (int k = int'(N); k > 0; k--) begin
      rr_sum = {1'b0, ptr} + SUM_W'(k);
      if (rr_sum >= SUM_W'(N)) begin
        rr_sum = rr_sum - SUM_W'(N);
      end
      if (s_tvalid[rr_sum[GNT_W-1:0]]) begin
        pick = rr_sum[GNT_W-1:0];
      end
    end
  end

  // Link path is a pure mux off the registered grant; no data storage here.
  always_comb begin
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = '0;
    m_tdata  = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (gnt == GNT_W'(i)) begin
        m_tdata = s_tdata[i*DATA_W +: DATA_W];
      end
    end
    if (state == BUSY) begin
      m_tvalid = s_tvalid[gnt];
      m_tlast  = s_tlast[gnt];
      s_tready = gnt_oh & {N{m_tready}};
    end
  end

  assign last_hs = m_tvalid & m_tready & m_tlast;

  // Grant is taken in IDLE and held until the owner's tlast handshake.
  always_comb begin
    state_next  = state;
    gnt_next    = gnt;
    gnt_oh_next = gnt_oh;
    busy_next   = busy;
    ptr_next    = ptr;
    case (state)
      IDLE: begin
        if (|s_tvalid) begin
          state_next  = BUSY;
          gnt_next    = pick;
          gnt_oh_next = N'(1) << pick;
          busy_next   = 1'b1;
        end
      end
      BUSY: begin
        if (last_hs) begin
          state_next  = IDLE;
          ptr_next    = gnt;
          gnt_oh_next = '0;
          busy_next   = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ptr resets to N-1 so requester 0 has top priority first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= '0;
      gnt_oh <= '0;
      busy   <= 1'b0;
      ptr    <= GNT_W'(N - 1);
    end else begin
      state  <= state_next;
      gnt    <= gnt_next;
      gnt_oh <= gnt_oh_next;
      busy   <= busy_next;
      ptr    <= ptr_next;
    end
  end

`ifdef NOC_PORT_ARB_PKT_CNT_EN
  // Completed-packet counter; a clear beats a coincident tlast handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt <= '0;
    end else if (pkt_cnt_clr) begin
      pkt_cnt <= '0;
    end else if (last_hs) begin
      pkt_cnt <= pkt_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_noc_port_arb.sv
// tb_noc_port_arb: randomized sources plus a packet-level round-robin reference model and scoreboard.
module tb_noc_port_arb;

  localparam int unsigned N      = 5;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned DEPTH  = 512;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [N-1:0]        s_tvalid = '0;
  logic [N-1:0]        s_tlast = '0;
  logic [N*DATA_W-1:0] s_tdata = '0;
  logic [N-1:0]        s_tready;
  logic                m_tvalid;
  logic                m_tready = 1'b1;
  logic [DATA_W-1:0]   m_tdata;
  logic                m_tlast;
  logic [N-1:0]        gnt_oh;
  logic                busy;
`ifdef NOC_PORT_ARB_PKT_CNT_EN
  logic                pkt_cnt_clr = 1'b0;
  logic [15:0]         pkt_cnt;
`endif

  noc_port_arb #(.N(N), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .gnt_oh(gnt_oh), .busy(busy)
`ifdef NOC_PORT_ARB_PKT_CNT_EN
    , .pkt_cnt_clr(pkt_cnt_clr), .pkt_cnt(pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Per-requester packet storage: beats are appended by stimulus, consumed by the driver.
  logic [DATA_W-1:0] bd [N][DEPTH];
  logic              bl [N][DEPTH];
  int                wr [N];
  int                rd [N];
  int                mrd [N];
  logic [N-1:0]      hs;
  int                bubble_pct = 0;
  bit                rdy_rand = 1'b0;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic add_pkt(input int src, input int len);
    for (int b = 0; b < len; b++) begin
      if (wr[src] < int'(DEPTH)) begin
        bd[src][wr[src]] = {$urandom(), $urandom()};
        bl[src][wr[src]] = (b == len - 1);
        wr[src]++;
      end
    end
  endtask

  // AXI-Stream sources: a presented beat holds until accepted; gaps only between beats.
  task automatic drive();
    for (int i = 0; i < int'(N); i++) begin
      if (!(s_tvalid[i] && !hs[i])) begin
        if (rd[i] < wr[i] && int'($urandom_range(99)) >= bubble_pct) begin
          s_tvalid[i] = 1'b1;
          s_tdata[i*DATA_W +: DATA_W] = bd[i][rd[i]];
          s_tlast[i] = bl[i][rd[i]];
        end else begin
          s_tvalid[i] = 1'b0;
          s_tlast[i]  = 1'b0;
        end
      end
    end
    if (rdy_rand) m_tready = ($urandom_range(99) >= 35);
  endtask

  task automatic tick();
    @(negedge clk);
    hs = s_tvalid & s_tready;
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(N); i++) if (hs[i]) rd[i]++;
    drive();
  endtask

  // Reference model state: packet-level owner, round-robin pointer, expected beat queue.
  logic [DATA_W:0] expq [$];
  bit              mbusy = 1'b0;
  int              mg = 0;
  int              mptr = int'(N) - 1;
  bit [15:0]       mcnt = '0;

  task automatic drain(input int budget);
    int  n = 0;
    bit  pend = 1'b1;
    while (pend && n < budget) begin
      pend = mbusy || (s_tvalid != '0);
      for (int i = 0; i < int'(N); i++) if (rd[i] < wr[i]) pend = 1'b1;
      if (pend) begin
        tick();
        n++;
      end
    end
    if (pend) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout: traffic still pending after %0d cycles, expected idle", budget);
    end
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Monitor: compare every cycle against the model, then advance the model.
  initial begin
    logic [DATA_W:0] beat;
    bit              lhs;
    int              c;
    @(posedge clk);
    forever begin
      @(negedge clk);
      lhs = 1'b0;
      chk("gnt_oh", 64'(gnt_oh), mbusy ? 64'(N'(1) << mg) : 64'd0);
      chk("busy", 64'(busy), 64'(mbusy));
      chk("m_tvalid", 64'(m_tvalid), mbusy ? 64'(s_tvalid[mg]) : 64'd0);
      chk("s_tready", 64'(s_tready), mbusy ? 64'(N'(m_tready) << mg) : 64'd0);
`ifdef NOC_PORT_ARB_PKT_CNT_EN
      chk("pkt_cnt", 64'(pkt_cnt), 64'(mcnt));
`endif
      if (mbusy && s_tvalid[mg]) begin
        if (expq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL scoreboard: beat from requester %0d with data %h, expected none", mg, m_tdata);
        end else begin
          chk("m_tdata", 64'(m_tdata), 64'(expq[0][DATA_W-1:0]));
          chk("m_tlast", 64'(m_tlast), 64'(expq[0][DATA_W]));
          if (m_tready) begin
            beat = expq.pop_front();
            lhs  = beat[DATA_W];
          end
        end
        if (lhs) begin
          mbusy = 1'b0;
          mptr  = mg;
        end
      end else if (!mbusy && s_tvalid != '0) begin
        for (int k = 1; k <= int'(N); k++) begin
          c = (mptr + k) % int'(N);
          if (s_tvalid[c]) begin
            mg = c;
            break;
          end
        end
        mbusy = 1'b1;
        while (mrd[mg] < wr[mg]) begin
          beat = {bl[mg][mrd[mg]], bd[mg][mrd[mg]]};
          expq.push_back(beat);
          mrd[mg]++;
          if (beat[DATA_W]) break;
        end
      end
`ifdef NOC_PORT_ARB_PKT_CNT_EN
      if (pkt_cnt_clr) mcnt = '0;
      else if (lhs) mcnt = mcnt + 16'd1;
`endif
      if (rst) begin
        mbusy = 1'b0;
        mptr  = int'(N) - 1;
        mcnt  = '0;
        expq.delete();
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < int'(N); i++) begin
      wr[i] = 0; rd[i] = 0; mrd[i] = 0;
    end
    hs = '0;

    // Reset with random request noise, then a quiet idle cycle.
    repeat (3) begin
      @(posedge clk);
      #1;
      s_tvalid = N'($urandom());
      m_tready = $urandom_range(1);
    end
    s_tvalid = '0;
    m_tready = 1'b1;
    rst = 1'b0;
    tick();
    chk("post_reset_idle", 64'({busy, m_tvalid, gnt_oh, s_tready}), 64'd0);

    // Single 3-beat packet from requester 2.
    add_pkt(2, 3);
    tick();
    tick();
    chk("single_gnt", 64'(gnt_oh), 64'(5'b00100));
    drain(50);
    chk("single_busy_done", 64'(busy), 64'd0);

    // Full contention with 1-beat packets from reset: 0,1,2,3,4,0 with idle gaps.
    do_reset();
    for (int i = 0; i < int'(N); i++) for (int p = 0; p < 3; p++) add_pkt(i, 1);
    tick();
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("rr_order", 64'(gnt_oh), (k % 2 == 1) ? 64'(N'(1) << (((k - 1) / 2) % int'(N))) : 64'd0);
    end
    drain(200);

    // Backpressure and bubbles: requester 1 multi-beat, requester 3 arrives mid-packet.
    bubble_pct = 40;
    rdy_rand   = 1'b1;
    add_pkt(1, 4);
    tick();
    tick();
    tick();
    add_pkt(3, 2);
    drain(300);

    // Random mixed traffic.
    bubble_pct = 30;
    for (int p = 0; p < 40; p++) add_pkt(int'($urandom_range(N - 1)), int'($urandom_range(5, 1)));
    drain(4000);

    // Reset on beat 2 of a packet from requester 4 while requester 0 waits.
    bubble_pct = 0;
    rdy_rand   = 1'b0;
    m_tready   = 1'b1;
    add_pkt(4, 4);
    n = 0;
    while (!(mbusy && mg == 4) && n < 10) begin
      tick();
      n++;
    end
    chk("rst_mid_gnt4", 64'(gnt_oh), 64'(5'b10000));
    add_pkt(0, 2);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd[4] = wr[4];
    mrd[4] = wr[4];
    s_tvalid[4] = 1'b0;
    s_tlast[4] = 1'b0;
    chk("rst_mid_idle", 64'({busy, m_tvalid, gnt_oh, s_tready}), 64'd0);
    tick();
    chk("rst_mid_next_gnt", 64'(gnt_oh), 64'(5'b00001));
    drain(50);

`ifdef NOC_PORT_ARB_PKT_CNT_EN
    // Packet counter: three packets, clear coincident with the fourth tlast, then wrap.
    do_reset();
    for (int p = 0; p < 3; p++) add_pkt(2, 1);
    drain(50);
    chk("pkt_cnt_three", 64'(pkt_cnt), 64'd3);
    add_pkt(2, 1);
    tick();
    tick();
    pkt_cnt_clr = 1'b1;
    chk("pkt_cnt_before_clr", 64'(pkt_cnt), 64'd3);
    tick();
    pkt_cnt_clr = 1'b0;
    chk("pkt_cnt_after_clr", 64'(pkt_cnt), 64'd0);
    force dut.pkt_cnt = 16'hFFFF;
    mcnt = 16'hFFFF;
    #1;
    release dut.pkt_cnt;
    add_pkt(2, 1);
    tick();
    tick();
    tick();
    chk("pkt_cnt_wrap", 64'(pkt_cnt), 64'd0);
    drain(20);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
